link_speed_clken: RTL
=====================

# link_speed_clken

Parametrised Ethernet link-speed detector and GMII TX clock-enable generator. It sits in the 125 MHz reference-clock domain between the RGMII/GMII converters and SiTCP. It measures the PHY RX clock rate through a divided toggle, then classifies the link as 10M, 100M or 1000M with hysteresis. From that result it drives the GMII mode flag and the TX clock-enable pattern used to gate the TX clock buffers.

## Interface
Parameters:
- WINDOW_W, 10: log2 of the measurement window in CLK cycles (default 1024 cycles).
- CNT_W, 8: width of the saturating edge counter.
- THR_1G, 64: minimum edges per window to classify as 1000M.
- THR_100M, 6: minimum edges per window to classify as 100M.
- HYST, 2: consecutive identical classifications required before the speed changes (1..15).
- DIV_100M, 5: CLK_EN_OUT period in 100M mode.
- DIV_10M, 50: CLK_EN_OUT period in 10M mode.

Ports:
- CLK in 1: 125 MHz reference clock; the only clock.
- SYS_RSTn in 1: synchronous, active-low reset.
- RXC_TGL_IN in 1: asynchronous level, toggled by the RX domain once every 8 RX clock cycles.
- SPEED_OUT out 2: 00 = 10M, 01 = 100M, 10 = 1000M; 11 is never driven.
- GMII_1000M_OUT out 1: 1 when SPEED_OUT = 10.
- CLK_EN_OUT out 1: TX clock-enable pattern.
- SPEED_CHG_OUT out 1: one-cycle pulse on every SPEED_OUT change.
- NO_CLK_OUT out 1: the last window saw zero edges.
- EDGE_CNT_OUT out CNT_W: edge count latched at the end of the last window (debug).

## Operation
- Input path: RXC_TGL_IN goes through a 2-FF synchroniser, then a delay register. An edge is sync XOR delayed, so both polarities count.
- Window counter: WIN_CNT (WINDOW_W bits) free-runs and wraps. At the terminal count (all ones):
  - EDGE_CNT_OUT latches the count.
  - The edge counter restarts at 0. An edge arriving in that same cycle loads the counter to 1; no edge is lost or double-counted.
- Edge counter saturates at 2^CNT_W-1 and does not wrap.
- Classification, registered one cycle after the latch:
  - count ≥ THR_1G gives 10.
  - otherwise count ≥ THR_100M gives 01.
  - otherwise 00.
  - count = 0 sets NO_CLK_OUT = 1 and the candidate is discarded: SPEED_OUT holds and the hysteresis counter clears.
  - Nonzero count clears NO_CLK_OUT.
- Hysteresis, with states per candidate:
  - Candidate equal to SPEED_OUT: match counter clears.
  - Candidate different and equal to the previous candidate: match counter increments.
  - Candidate different from the previous candidate: match counter resets to 1.
  - When the match counter reaches HYST: SPEED_OUT updates, SPEED_CHG_OUT pulses, and the match counter clears.
- Clock-enable generator:
  - 1000M: CLK_EN_OUT is 1 every cycle.
  - 100M / 10M: a divider counts 0..DIV-1 and CLK_EN_OUT = 1 only when the divider is 0.
  - On SPEED_CHG the divider reloads to 0. CLK_EN_OUT is high in the cycle after the pulse, and the new period starts there.
- Reset mid-operation: all state returns to reset values on the next edge; the window restarts at 0.

## Timing
- Reset values: SPEED_OUT = 00, GMII_1000M_OUT = 0, CLK_EN_OUT = 0, SPEED_CHG_OUT = 0, NO_CLK_OUT = 1, EDGE_CNT_OUT = 0; all counters 0.
- Toggle-to-counted latency: 3 CLK cycles.
- Terminal count to EDGE_CNT_OUT: +1 cycle. Terminal count to classification: +2 cycles. Terminal count to SPEED_OUT / SPEED_CHG_OUT: +3 cycles.
- GMII_1000M_OUT is registered together with SPEED_OUT, in the same cycle.
- Minimum reaction to a speed change is HYST windows plus 3 cycles.
- First CLK_EN_OUT after reset is 1 cycle after reset release, with 10M spacing.

## Configuration
- LINK_SPEED_FORCE_EN defined:
  - Adds ports FORCE_IN (in, 1) and FORCE_SPEED_IN (in, 2).
  - While FORCE_IN = 1, SPEED_OUT follows FORCE_SPEED_IN (11 maps to 10) one cycle later.
  - Hysteresis is bypassed, SPEED_CHG_OUT still pulses on each change, and measurement and NO_CLK_OUT continue.
  - When FORCE_IN returns to 0, the next completed window behaves as a normal candidate.
- Not defined: the ports are absent and speed comes only from detection.

## Structure
- Shared package link_speed_pkg: speed encoding typedef (SPD_10M, SPD_100M, SPD_1G) and default divide and threshold constants.
- One sub-module, rxc_edge_meter, containing the synchroniser, edge detect, window counter and saturating counter. It outputs the latched count and a window-done strobe. Classification, hysteresis and the enable divider stay in the top.

## Test plan
- 1000M detection: toggle every 8 CLK cycles (128 edges per window). After 2 windows: SPEED_OUT = 10, GMII_1000M_OUT = 1, CLK_EN_OUT constant 1, one SPEED_CHG_OUT pulse.
- 100M detection: toggle every 40 cycles (about 25 edges per window). After 2 windows: SPEED_OUT = 01 and CLK_EN_OUT high 1 of every 5 cycles.
- Hysteresis: 1000M stable, then a single window at the 100M rate, then 1000M again. SPEED_OUT stays 10 and there is no SPEED_CHG_OUT pulse.
- No clock: hold the toggle input for 2 windows. NO_CLK_OUT = 1, SPEED_OUT holds its last value, EDGE_CNT_OUT = 0.
- Boundary: inject an edge exactly at WIN_CNT terminal. The next window's EDGE_CNT_OUT includes it once. Drive more than 255 edges per window; EDGE_CNT_OUT saturates at 255.
- Reset mid-window at 1000M: assert SYS_RSTn = 0 for 1 cycle. Next cycle all outputs are at reset values, and 1000M is re-acquired after 2 full windows.

Source files
------------

// File: rtl/link_speed_pkg.sv
// link_speed_pkg: shared speed encoding and default constants for the
// link-speed detector / GMII TX clock-enable generator.
package link_speed_pkg;

   typedef enum logic [1:0] {
      SPD_10M  = 2'b00,
      SPD_100M = 2'b01,
      SPD_1G   = 2'b10
   } speed_e;

   localparam int unsigned DEF_WINDOW_W = 10;
   localparam int unsigned DEF_CNT_W    = 8;
   localparam int unsigned DEF_THR_1G   = 64;
   localparam int unsigned DEF_THR_100M = 6;
   localparam int unsigned DEF_HYST     = 2;
   localparam int unsigned DEF_DIV_100M = 5;
   localparam int unsigned DEF_DIV_10M  = 50;

   // Map an edges-per-window count onto a speed class.
   function automatic speed_e classify_speed(input int unsigned cnt,
                                             input int unsigned thr_1g,
                                             input int unsigned thr_100m);
      if (cnt >= thr_1g)
         return SPD_1G;
      else if (cnt >= thr_100m)
         return SPD_100M;
      return SPD_10M;
   endfunction

   // Forced speed code: the unused code 11 is treated as 1000M.
   function automatic speed_e force_map(input logic [1:0] code);
      return (code == 2'b11) ? SPD_1G : speed_e'(code);
   endfunction

endpackage

// File: rtl/link_speed_clken_meter.sv
// rxc_edge_meter: synchronises the RX-domain toggle, detects both edge
// polarities and counts them (saturating) over a free-running window.
// At the window's terminal count the total is latched and o_win_done
// pulses alongside the new latched value.
module rxc_edge_meter
   import link_speed_pkg::*;
#(
   parameter int unsigned WINDOW_W = DEF_WINDOW_W,
   parameter int unsigned CNT_W    = DEF_CNT_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_rxc_tgl,
   output logic [CNT_W-1:0] o_edge_cnt,
   output logic             o_win_done
);

   logic                r_sync1;
   logic                r_sync2;
   logic                r_dly;
   logic [WINDOW_W-1:0] r_win_cnt;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    r_latch;
   logic                r_done;

   logic w_edge;
   logic w_tc;
   logic w_sat;

   assign w_edge = r_sync2 ^ r_dly;
   assign w_tc   = &r_win_cnt;
   assign w_sat  = &r_cnt;

   // Two-flop synchroniser followed by the edge-detect delay stage.
   // NOTE: non-blocking (<=) makes each flop take its neighbour's pre-edge
   // value; blocking here would collapse the chain into a single stage.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_dly   <= 1'b0;
      end else begin
         r_sync1 <= i_rxc_tgl;
         r_sync2 <= r_sync1;
         r_dly   <= r_sync2;
      end
   end

   // Free-running measurement window counter, wraps at all ones.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         r_win_cnt <= '0;
      else
         r_win_cnt <= r_win_cnt + 1'b1;
   end

   // Saturating edge counter; an edge on the terminal cycle opens the next window.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt   <= '0;
         r_latch <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_tc;
         if (w_tc) begin
            r_latch <= r_cnt;
            r_cnt   <= w_edge ? CNT_W'(1) : '0;
         end else if (w_edge && !w_sat) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_edge_cnt = r_latch;
   assign o_win_done = r_done;

endmodule

// File: rtl/link_speed_clken.sv
// link_speed_clken: classifies the PHY RX clock rate as 10M/100M/1000M with
// hysteresis and generates the GMII mode flag and TX clock-enable pattern.
// Optional feature macro: LINK_SPEED_FORCE_EN adds FORCE_IN / FORCE_SPEED_IN
// to override the detected speed (measurement keeps running).
module link_speed_clken
   import link_speed_pkg::*;
#(
   parameter int unsigned WINDOW_W = DEF_WINDOW_W,
   parameter int unsigned CNT_W    = DEF_CNT_W,
   parameter int unsigned THR_1G   = DEF_THR_1G,
   parameter int unsigned THR_100M = DEF_THR_100M,
   parameter int unsigned HYST     = DEF_HYST,
   parameter int unsigned DIV_100M = DEF_DIV_100M,
   parameter int unsigned DIV_10M  = DEF_DIV_10M
) (
   input  logic             CLK,
   input  logic             SYS_RSTn,
   input  logic             RXC_TGL_IN,
`ifdef LINK_SPEED_FORCE_EN
   input  logic             FORCE_IN,
   input  logic [1:0]       FORCE_SPEED_IN,
`endif
   output logic [1:0]       SPEED_OUT,
   output logic             GMII_1000M_OUT,
   output logic             CLK_EN_OUT,
   output logic             SPEED_CHG_OUT,
   output logic             NO_CLK_OUT,
   output logic [CNT_W-1:0] EDGE_CNT_OUT
);

   localparam int unsigned DIV_MAX = (DIV_10M > DIV_100M) ? DIV_10M : DIV_100M;
   localparam int unsigned DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

   logic [CNT_W-1:0] w_latched;
   logic             w_win_done;

   speed_e           r_cand;
   speed_e           r_prev_cand;
   speed_e           r_speed;
   logic             r_cand_vld;
   logic             r_no_clk;
   logic             r_gmii;
   logic             r_chg;
   logic [3:0]       r_match;
   logic             r_clk_en;
   logic [DIV_W-1:0] r_div;

   speed_e           w_spd_nxt;
   logic [3:0]       w_match_nxt;
   logic [DIV_W-1:0] w_div_cur;
   logic [DIV_W-1:0] w_div_lim;

   rxc_edge_meter #(
      .WINDOW_W (WINDOW_W),
      .CNT_W    (CNT_W)
   ) u_meter (
      .i_clk      (CLK),
      .i_rst_n    (SYS_RSTn),
      .i_rxc_tgl  (RXC_TGL_IN),
      .o_edge_cnt (w_latched),
      .o_win_done (w_win_done)
   );

   // Register the window's speed class and the zero-edge flag.
   always_ff @(posedge CLK) begin
      if (!SYS_RSTn) begin
         r_cand     <= SPD_10M;
         r_cand_vld <= 1'b0;
         r_no_clk   <= 1'b1;
      end else begin
         r_cand_vld <= w_win_done;
         if (w_win_done) begin
            r_cand   <= classify_speed(32'(w_latched), THR_1G, THR_100M);
            r_no_clk <= (w_latched == '0);
         end
      end
   end

   // Hysteresis: a new speed needs HYST consecutive identical candidates.
   // NOTE: every output gets its default first, so no path can leave one
   // unassigned and infer a latch.
   always_comb begin
      w_spd_nxt   = r_speed;
      w_match_nxt = r_match;
`ifdef LINK_SPEED_FORCE_EN
      if (FORCE_IN) begin
         w_match_nxt = '0;
         w_spd_nxt   = force_map(FORCE_SPEED_IN);
      end else
`endif
      if (r_cand_vld) begin
         if (r_no_clk || (r_cand == r_speed))
            w_match_nxt = '0;
         else if (r_cand == r_prev_cand)
            w_match_nxt = r_match + 4'd1;
         else
            w_match_nxt = 4'd1;
         if (w_match_nxt == 4'(HYST)) begin
            w_spd_nxt   = r_cand;
            w_match_nxt = '0;
         end
      end
   end

   // Speed state, GMII flag and change pulse all update in the same cycle.
   always_ff @(posedge CLK) begin
      if (!SYS_RSTn) begin
         r_speed     <= SPD_10M;
         r_prev_cand <= SPD_10M;
         r_gmii      <= 1'b0;
         r_chg       <= 1'b0;
         r_match     <= '0;
      end else begin
         r_speed <= w_spd_nxt;
         r_gmii  <= (w_spd_nxt == SPD_1G);
         r_chg   <= (w_spd_nxt != r_speed);
         r_match <= w_match_nxt;
         if (r_cand_vld && !r_no_clk)
            r_prev_cand <= r_cand;
      end
   end

   // A speed change restarts the divider so the new period begins at once.
   always_comb begin
      w_div_cur = r_chg ? '0 : r_div;
      w_div_lim = (r_speed == SPD_100M) ? DIV_W'(DIV_100M - 1) : DIV_W'(DIV_10M - 1);
   end

   // TX clock-enable: every cycle at 1000M, one cycle per divide period otherwise.
   always_ff @(posedge CLK) begin
      if (!SYS_RSTn) begin
         r_div    <= '0;
         r_clk_en <= 1'b0;
      end else if (r_speed == SPD_1G) begin
         r_div    <= '0;
         r_clk_en <= 1'b1;
      end else begin
         r_clk_en <= (w_div_cur == '0);
         r_div    <= (w_div_cur >= w_div_lim) ? '0 : w_div_cur + 1'b1;
      end
   end

   assign SPEED_OUT      = r_speed;
   assign GMII_1000M_OUT = r_gmii;
   assign CLK_EN_OUT     = r_clk_en;
   assign SPEED_CHG_OUT  = r_chg;
   assign NO_CLK_OUT     = r_no_clk;
   assign EDGE_CNT_OUT   = w_latched;

endmodule
